// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and fixed widths for the 16/8 divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_N    = 16;
  localparam int DIV_D    = 8;
  localparam int DIV_ITER = 8;
endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/sub_9b.sv
// rtl/sub_9b.sv - 9-bit ripple subtractor a - b built from full_adder cells
module sub_9b (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);
  logic [9:0] c;

  // a + ~b + 1; a missing carry-out means the result went negative
  assign c[0] = 1'b1;

  for (genvar i = 0; i < 9; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (c[i]),
      .s   (diff[i]),
      .cout(c[i+1])
    );
  end

  assign borrow = ~c[9];
endmodule

// File: rtl/seq_divider_16x8.sv
// rtl/seq_divider_16x8.sv - sequential restoring divider, 16-bit / 8-bit, one quotient bit per clock
module seq_divider_16x8
  import div_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIV_N-1:0]   dividend,
  input  logic [DIV_D-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIV_D-1:0]   quotient,
  output logic [DIV_D-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);
  div_state_t       state, state_nxt;
  logic [2:0]       cnt;
  logic [DIV_D-1:0] r, dsr, q, dvsr;
  logic             dz, ov;
  logic [8:0]       t, d;
  logic             borrow, qbit, accept;

  assign accept = in_valid && in_ready;
  assign t      = {r, dsr[DIV_D-1]};

  sub_9b u_sub (
    .a     (t),
    .b     ({1'b0, dvsr}),
    .diff  (d),
    .borrow(borrow)
  );

  // r < divisor keeps a non-borrowing difference below 256, so d[8] is only set on borrow
  assign qbit = ~(borrow | d[8]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      // flagged operations pass through CALC for one edge without iterating
      CALC: if (dz || ov || cnt == 3'(DIV_ITER - 1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      r    <= '0;
      dsr  <= '0;
      q    <= '0;
      dvsr <= '0;
      dz   <= 1'b0;
      ov   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvsr <= divisor;
            dsr  <= dividend[DIV_D-1:0];
            cnt  <= '0;
            if (divisor == '0) begin
              dz <= 1'b1;
              ov <= 1'b0;
              q  <= '1;
              r  <= dividend[DIV_D-1:0];
            end else if (dividend[DIV_N-1:DIV_D] >= divisor) begin
              dz <= 1'b0;
              ov <= 1'b1;
              q  <= '1;
              r  <= '1;
            end else begin
              dz <= 1'b0;
              ov <= 1'b0;
              q  <= '0;
              r  <= dividend[DIV_N-1:DIV_D];
            end
          end
        end
        CALC: begin
          if (!(dz || ov)) begin
            r   <= qbit ? d[7:0] : t[7:0];
            q   <= {q[DIV_D-2:0], qbit};
            dsr <= {dsr[DIV_D-2:0], 1'b0};
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = q;
  assign remainder = r;
  assign div_zero  = dz;
  assign overflow  = ov;
endmodule

// File: tb/tb_seq_divider_16x8.sv
// tb/tb_seq_divider_16x8.sv - directed self-checking bench for seq_divider_16x8
module tb_seq_divider_16x8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  seq_divider_16x8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // one transaction up to out_valid; lat = edges after the accept edge
  task automatic do_op(input logic [15:0] p, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov, output int lat);
    @(negedge clk);
    dividend = p;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'h00;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    ov = overflow;
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if ({quotient, remainder, div_zero, overflow} !== 18'h0) begin
      fails++; $display("FAIL reset_outputs got q=%h r=%h dz=%b ov=%b want zeros", quotient, remainder, div_zero, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_exact();
    logic [7:0] q, r; logic dz, ov; int lat;
    do_op(16'hFE01, 8'hFF, q, r, dz, ov, lat);
    tests++; if (lat !== 8)   begin fails++; $display("FAIL exact_latency got %0d want 8", lat); end
    tests++; if (q !== 8'hFF) begin fails++; $display("FAIL exact_quotient got %h want ff", q); end
    tests++; if (r !== 8'h00) begin fails++; $display("FAIL exact_remainder got %h want 00", r); end
    tests++; if ({dz, ov} !== 2'b00) begin fails++; $display("FAIL exact_flags got dz=%b ov=%b want 0 0", dz, ov); end
    pop();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL exact_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_calc_overflow();
    logic [7:0] q, r; logic dz, ov; int lat;
    do_op(16'h1234, 8'h25, q, r, dz, ov, lat);
    tests++; if (q !== 8'h7D || r !== 8'h23) begin fails++; $display("FAIL calc_1234 got q=%h r=%h want 7d 23", q, r); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL calc_latency got %0d want 8", lat); end
    pop();
    do_op(16'h0100, 8'h01, q, r, dz, ov, lat);
    tests++; if (q !== 8'hFF || r !== 8'hFF) begin fails++; $display("FAIL ovf_values got q=%h r=%h want ff ff", q, r); end
    tests++; if ({dz, ov} !== 2'b01) begin fails++; $display("FAIL ovf_flags got dz=%b ov=%b want 0 1", dz, ov); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL ovf_latency got %0d want 1", lat); end
    pop();
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic dz, ov; int lat;
    do_op(16'hABCD, 8'h00, q, r, dz, ov, lat);
    tests++; if (q !== 8'hFF || r !== 8'hCD) begin fails++; $display("FAIL dz_values got q=%h r=%h want ff cd", q, r); end
    tests++; if ({dz, ov} !== 2'b10) begin fails++; $display("FAIL dz_flags got dz=%b ov=%b want 1 0", dz, ov); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL dz_latency got %0d want 1", lat); end
    pop();
  endtask

  task automatic test_backpressure();
    logic [7:0] q, r; logic dz, ov; int lat;
    do_op(16'h1234, 8'h25, q, r, dz, ov, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; dividend = 16'h0001; divisor = 8'h01;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'h7D || remainder !== 8'h23 ||
          div_zero !== 1'b0 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got ov=%b ir=%b q=%h r=%h want 1 0 7d 23", i, out_valid, in_ready, quotient, remainder);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; dividend = 16'h0064; divisor = 8'h0A;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; dividend = 16'hDEAD; divisor = 8'h00;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_next_accept got in_ready=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++; if (lat !== 8 || quotient !== 8'h0A || remainder !== 8'h00) begin
      fails++; $display("FAIL bp_next_result got lat=%0d q=%h r=%h want 8 0a 00", lat, quotient, remainder);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r; logic dz, ov; int lat; int seen;
    @(negedge clk);
    dividend = 16'h1234; divisor = 8'h25; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_async got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    tests++; if (quotient !== 8'h00 || remainder !== 8'h00) begin
      fails++; $display("FAIL midrst_values got q=%h r=%h want 00 00", quotient, remainder);
    end
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_pulse got %0d valid cycles want 0", seen); end
    do_op(16'h0064, 8'h0A, q, r, dz, ov, lat);
    tests++; if (q !== 8'h0A || r !== 8'h00 || lat !== 8) begin
      fails++; $display("FAIL midrst_after got q=%h r=%h lat=%0d want 0a 00 8", q, r, lat);
    end
    pop();
  endtask

  task automatic test_round_trip();
    logic [7:0] q, r, a, b; logic dz, ov; int lat;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(16'(a) * 16'(b), b, q, r, dz, ov, lat);
      tests++;
      if (q !== a || r !== 8'h00 || dz !== 1'b0 || ov !== 1'b0 || lat !== 8) begin
        fails++;
        $display("FAIL round_trip a=%h b=%h got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=00 lat=8", a, b, q, r, dz, ov, lat, a);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      pop();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_calc_overflow();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
